// File: rtl/mcpu_irq_ctrl.sv
// Interrupt controller on the main Z80 I/O bus: edge-latched sources, mode-2 vectored acknowledge.
// Optional NMI pulse generator built only when MCPU_IRQ_NMI_EN is defined.
module mcpu_irq_ctrl #(
  parameter logic [7:0]  PORT_BASE = 8'h00,
  parameter int unsigned NSRC      = 4,
  parameter int unsigned NMI_PULSE = 32
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic [15:0]     mcpu_ab,
  input  logic [7:0]      mcpu_dout,
  input  logic            mcpu_wr,
  input  logic            mcpu_rd,
  input  logic            mcpu_io,
  input  logic            mcpu_m1,
  input  logic [NSRC-1:0] irq_src,
`ifdef MCPU_IRQ_NMI_EN
  input  logic            nmi_src,
  output logic            mcpu_nmi_n,
`endif
  output logic [7:0]      mcpu_din,
  output logic            mcpu_int_n
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  localparam logic [7:0] AddrMask = PORT_BASE;
  localparam logic [7:0] AddrPend = PORT_BASE + 8'd1;
  localparam logic [7:0] AddrBase = PORT_BASE + 8'd2;

  logic [0:0]      state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] src_q;
  logic [3:0]      vbase_q, vbase_d;
  logic [7:0]      din_q, din_d;
  logic            int_n_q, int_n_d;
  logic            wr_q, ack_q, live_q;

  logic            wr_now, ack_now, wr_edge, ack_edge;
  logic [NSRC-1:0] active, sel, set, clr;
  logic [2:0]      idx;
  logic            found;
  logic [7:0]      rd_data;

  logic unused_bus;
  assign unused_bus = ^{mcpu_ab[15:8], mcpu_rd, mcpu_dout[3:0]};

  assign wr_now   = mcpu_io & mcpu_wr & ~mcpu_m1;
  assign ack_now  = mcpu_io & mcpu_m1;
  assign wr_edge  = wr_now & ~wr_q;
  assign ack_edge = ack_now & ~ack_q & (state_q == StIdle);
  // live_q masks the first cycle after reset so sources already high are not taken as edges.
  assign set      = irq_src & ~src_q & {NSRC{live_q}};
  assign active   = pend_q & mask_q;

  always_comb begin
    found = 1'b0;
    idx   = 3'd7;
    sel   = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && active[i]) begin
        found  = 1'b1;
        idx    = 3'(i);
        sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d  = mask_q;
    vbase_d = vbase_q;
    clr     = '0;
    if (wr_edge) begin
      if (mcpu_ab[7:0] == AddrMask) mask_d = mcpu_dout[NSRC-1:0];
      if (mcpu_ab[7:0] == AddrPend) clr = mcpu_dout[NSRC-1:0];
      if (mcpu_ab[7:0] == AddrBase) vbase_d = mcpu_dout[7:4];
    end
    if (ack_edge) clr = clr | sel;
    pend_d = (pend_q & ~clr) | set;
  end

  always_comb begin
    rd_data = 8'hFF;
    if (mcpu_ab[7:0] == AddrMask) rd_data = 8'(mask_q);
    if (mcpu_ab[7:0] == AddrPend) rd_data = 8'(pend_q);
    if (mcpu_ab[7:0] == AddrBase) rd_data = {vbase_q, 4'h0};

    state_d = state_q;
    din_d   = rd_data;
    if (state_q == StAck) begin
      din_d = din_q;
      if (!ack_now) state_d = StIdle;
    end else if (ack_edge) begin
      din_d   = {vbase_q, idx, 1'b0};
      state_d = StAck;
    end
    int_n_d = ~((state_q == StIdle) & ~ack_edge & (|active));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      pend_q  <= '0;
      src_q   <= '0;
      vbase_q <= 4'h0;
      din_q   <= 8'hFF;
      int_n_q <= 1'b1;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      src_q   <= irq_src;
      vbase_q <= vbase_d;
      din_q   <= din_d;
      int_n_q <= int_n_d;
      wr_q    <= wr_now;
      ack_q   <= ack_now;
      live_q  <= 1'b1;
    end
  end

  assign mcpu_din   = din_q;
  assign mcpu_int_n = int_n_q;

`ifdef MCPU_IRQ_NMI_EN
  localparam int unsigned CntW = $clog2(NMI_PULSE + 1);

  logic            nmi_src_q, nmi_n_q, nmi_n_d;
  logic [CntW-1:0] nmi_cnt_q, nmi_cnt_d;

  // Pulse is NMI_PULSE clks: load PULSE-1, release on the edge after the count reaches zero.
  always_comb begin
    nmi_n_d   = nmi_n_q;
    nmi_cnt_d = nmi_cnt_q;
    if (!nmi_n_q) begin
      if (nmi_cnt_q == '0) nmi_n_d = 1'b1;
      else                 nmi_cnt_d = nmi_cnt_q - 1'b1;
    end else if (nmi_src && !nmi_src_q && live_q) begin
      nmi_n_d   = 1'b0;
      nmi_cnt_d = CntW'(NMI_PULSE - 1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      nmi_src_q <= 1'b0;
      nmi_n_q   <= 1'b1;
      nmi_cnt_q <= '0;
    end else begin
      nmi_src_q <= nmi_src;
      nmi_n_q   <= nmi_n_d;
      nmi_cnt_q <= nmi_cnt_d;
    end
  end

  assign mcpu_nmi_n = nmi_n_q;
`endif

endmodule

// File: tb/tb_mcpu_irq_ctrl.sv
// Directed bench for mcpu_irq_ctrl: register access, vectored acknowledge, priority and corner cases.
module tb_mcpu_irq_ctrl;

  localparam logic [7:0] Base = 8'h00;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mcpu_ab = '0;
  logic [7:0]  mcpu_dout = '0;
  logic        mcpu_wr = 1'b0, mcpu_rd = 1'b0, mcpu_io = 1'b0, mcpu_m1 = 1'b0;
  logic [3:0]  irq_src = '0;
  logic [7:0]  mcpu_din;
  logic        mcpu_int_n;
`ifdef MCPU_IRQ_NMI_EN
  logic        nmi_src = 1'b0;
  logic        mcpu_nmi_n;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mcpu_irq_ctrl #(.PORT_BASE(Base), .NSRC(4), .NMI_PULSE(32)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .mcpu_ab   (mcpu_ab),
    .mcpu_dout (mcpu_dout),
    .mcpu_wr   (mcpu_wr),
    .mcpu_rd   (mcpu_rd),
    .mcpu_io   (mcpu_io),
    .mcpu_m1   (mcpu_m1),
    .irq_src   (irq_src),
`ifdef MCPU_IRQ_NMI_EN
    .nmi_src   (nmi_src),
    .mcpu_nmi_n(mcpu_nmi_n),
`endif
    .mcpu_din  (mcpu_din),
    .mcpu_int_n(mcpu_int_n)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    mcpu_ab = {8'h00, addr}; mcpu_dout = data; mcpu_io = 1'b1; mcpu_wr = 1'b1;
    cycles(2);
    mcpu_io = 1'b0; mcpu_wr = 1'b0;
    cycles(1);
  endtask

  task automatic io_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    mcpu_ab = {8'h00, addr}; mcpu_io = 1'b1; mcpu_rd = 1'b1;
    cycles(2);
    check_eq(tag, {8'h00, mcpu_din}, {8'h00, exp});
    mcpu_io = 1'b0; mcpu_rd = 1'b0;
    cycles(1);
  endtask

  task automatic pulse_irq(input logic [3:0] bits);
    irq_src = bits;
    cycles(1);
    irq_src = '0;
    cycles(3);
  endtask

  task automatic ack_begin;
    mcpu_io = 1'b1; mcpu_m1 = 1'b1;
    cycles(2);
  endtask

  task automatic ack_end;
    mcpu_io = 1'b0; mcpu_m1 = 1'b0;
    cycles(2);
  endtask

  initial begin
    cycles(2);
    check_eq("rst_int_n", {15'h0, mcpu_int_n}, 16'h1);
    check_eq("rst_din", {8'h00, mcpu_din}, 16'h00FF);

    // A source held high across reset release must not pend.
    irq_src = 4'b1000;
    reset_n = 1'b1;
    cycles(3);
    irq_src = '0;
    check_eq("rel_int_n", {15'h0, mcpu_int_n}, 16'h1);
    io_read("rd_imask0", Base, 8'h00);
    io_read("rd_ipend0", Base + 8'd1, 8'h00);
    io_read("rd_vbase0", Base + 8'd2, 8'h00);
    io_read("rd_undec", Base + 8'd3, 8'hFF);

    // Single source, vectored acknowledge.
    io_write(Base, 8'h0F);
    io_write(Base + 8'd2, 8'h80);
    io_write(Base + 8'd5, 8'h00);
    io_read("rd_imask", Base, 8'h0F);
    io_read("rd_vbase", Base + 8'd2, 8'h80);
    pulse_irq(4'b0100);
    check_eq("t2_int_lo", {15'h0, mcpu_int_n}, 16'h0);
    io_read("t2_ipend", Base + 8'd1, 8'h04);
    ack_begin();
    check_eq("t2_vec", {8'h00, mcpu_din}, 16'h0084);
    check_eq("t2_int_ack", {15'h0, mcpu_int_n}, 16'h1);
    ack_end();
    check_eq("t2_int_hi", {15'h0, mcpu_int_n}, 16'h1);
    io_read("t2_ipend_clr", Base + 8'd1, 8'h00);

    // Two simultaneous sources are served in priority order.
    pulse_irq(4'b1010);
    check_eq("t3_int_lo", {15'h0, mcpu_int_n}, 16'h0);
    ack_begin();
    check_eq("t3_vec1", {8'h00, mcpu_din}, 16'h0082);
    ack_end();
    check_eq("t3_int_re", {15'h0, mcpu_int_n}, 16'h0);
    ack_begin();
    check_eq("t3_vec2", {8'h00, mcpu_din}, 16'h0086);
    ack_end();
    check_eq("t3_int_hi", {15'h0, mcpu_int_n}, 16'h1);

    // Masked source pends without interrupting; W1C; spurious acknowledge.
    io_write(Base, 8'h00);
    pulse_irq(4'b0001);
    check_eq("t4_int_masked", {15'h0, mcpu_int_n}, 16'h1);
    io_read("t4_ipend", Base + 8'd1, 8'h01);
    io_write(Base + 8'd1, 8'h01);
    io_read("t4_ipend_w1c", Base + 8'd1, 8'h00);
    ack_begin();
    check_eq("t4_spurious", {8'h00, mcpu_din}, 16'h008E);
    ack_end();

    // Masking off a pending source releases int_n but keeps pend.
    io_write(Base, 8'h0F);
    pulse_irq(4'b0010);
    check_eq("mask_int_lo", {15'h0, mcpu_int_n}, 16'h0);
    io_write(Base, 8'h00);
    check_eq("mask_int_hi", {15'h0, mcpu_int_n}, 16'h1);
    io_read("mask_pend_kept", Base + 8'd1, 8'h02);
    io_write(Base + 8'd1, 8'h02);

    // Edge and W1C on the same bit in the same clock: the set wins.
    mcpu_ab = {8'h00, Base + 8'd1}; mcpu_dout = 8'h01; mcpu_io = 1'b1; mcpu_wr = 1'b1;
    irq_src = 4'b0001;
    cycles(1);
    irq_src = '0;
    cycles(1);
    mcpu_io = 1'b0; mcpu_wr = 1'b0;
    cycles(1);
    io_read("t5_set_wins", Base + 8'd1, 8'h01);

    // Edge during ACK keeps the frozen vector; reset mid-ACK restores reset state.
    io_write(Base, 8'h01);
    check_eq("t5_int_lo", {15'h0, mcpu_int_n}, 16'h0);
    ack_begin();
    check_eq("t5_vec", {8'h00, mcpu_din}, 16'h0080);
    irq_src = 4'b0001;
    cycles(1);
    irq_src = '0;
    cycles(2);
    check_eq("t5_vec_frozen", {8'h00, mcpu_din}, 16'h0080);
    reset_n = 1'b0;
    cycles(1);
    check_eq("t5_rst_din", {8'h00, mcpu_din}, 16'h00FF);
    check_eq("t5_rst_int_n", {15'h0, mcpu_int_n}, 16'h1);
    mcpu_io = 1'b0; mcpu_m1 = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(2);
    io_read("t5_rst_imask", Base, 8'h00);
    io_read("t5_rst_ipend", Base + 8'd1, 8'h00);
    io_read("t5_rst_vbase", Base + 8'd2, 8'h00);

`ifdef MCPU_IRQ_NMI_EN
    begin
      int low_cnt;
      low_cnt = 0;
      nmi_src = 1'b1;
      cycles(1);
      nmi_src = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (mcpu_nmi_n == 1'b0) low_cnt++;
        if (i == 10) nmi_src = 1'b1;
        if (i == 12) nmi_src = 1'b0;
        cycles(1);
      end
      check_eq("nmi_width", 16'(low_cnt), 16'd32);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
